idu_is_lsiq: RTL and testbench
==============================

Name: idu_is_lsiq

Overview:
Parametrised load/store issue queue for the IDU issue stage. It holds up to DEPTH renamed memory ops in a circular buffer and tracks source-operand readiness per entry through WAKE_NUM generic wakeup ports. Ops issue strictly in program order: only the head may issue, and it issues to the LSU with a valid/ready handshake. It replaces the single-entry LSIQ slot with a multi-entry queue that has backpressure, occupancy reporting and a pop handshake.

Parameters:
DEPTH, 8, number of entries; must be a power of two and at least 2.
WAKE_NUM, 10, number of wakeup (forward/result) ports.
PREG_W, 6, physical register index width.
IID_W, 5, instruction id width.
PTR_W, $clog2(DEPTH), pointer width; derived, not overridable.

Ports:
clk  in  1  core clock
rst_clk  in  1  asynchronous active-low reset
rtu_global_flush  in  1  flush all entries
create_vld  in  1  enqueue request
create_rdy  out  1  queue can accept; equals !full
create_iid/opcode/funct7/funct3/pc  in  IID_W/7/7/3/64  op payload
create_psrc1_vld, create_psrc1_ready, create_psrc1  in  1,1,PREG_W  source 1
create_psrc2_vld, create_psrc2_ready, create_psrc2  in  1,1,PREG_W  source 2
create_pdst_vld, create_pdst  in  1,PREG_W  destination
create_imm_vld, create_imm  in  1,64  immediate
wake_vld  in  WAKE_NUM  per-port wakeup valid
wake_preg  in  WAKE_NUM*PREG_W  port k occupies bits [k*PREG_W +: PREG_W]
issue_vld  out  1  head entry valid and ready
issue_rdy  in  1  LSU accepts
issue_iid ... issue_imm  out  same widths as create_*  head payload; pdst is forced to 0 when pdst_vld=0
count  out  PTR_W+1  number of occupied entries

Behaviour:
- Reset: all entries invalid, all payload and ready bits 0, head = tail = 0, count = 0, create_rdy = 1, issue_vld = 0, issue_* = 0.
- Storage: a circular buffer with head and tail pointers. full = (count == DEPTH); empty = (count == 0). Pointers wrap from DEPTH-1 to 0.
- Wake match for a source s: OR over k of (wake_vld[k] & wake_preg[k] == s).
- Source ready: src_ok = !psrc_vld | psrc_ready.
  - An invalid source counts as ready. This is new behaviour; the old slot ignored the vld bit.
- Enqueue (create_vld & create_rdy):
  - Write the payload at tail; tail increments.
  - Captured psrcN_ready = create_psrcN_ready | wake match on create_psrcN in the same cycle.
  - Stored pdst = create_pdst_vld ? create_pdst : 0.
  - create_vld while full is dropped with no state change; the sender must hold it.
- Every valid entry not being written ORs in its wake match each cycle. Ready bits are sticky until the entry is freed.
- Issue:
  - issue_vld = !empty & src1_ok & src2_ok of the head, read from registered state only (combinational from flops).
  - issue_* always shows the head payload, and 0 when empty.
  - Pop on issue_vld & issue_rdy: head entry is cleared to 0 and head increments.
  - issue_vld must not depend on issue_rdy.
  - A wakeup arriving in cycle t makes the head issuable at t+1.
- Latency: an op created ready at cycle t into an empty queue gives issue_vld=1 at t+1. There is no create-to-issue bypass.
- Simultaneous enqueue and pop: both occur; count is unchanged. create_rdy uses the current count, so a full queue refuses create even in a cycle that pops.
- Younger ready entries never issue ahead of a non-ready head.
- Flush has priority over create and pop in the same cycle:
  - Next cycle: all entries invalid, payload 0, head = tail = 0, count = 0.
  - issue_vld stays combinational on state, so it is 0 from the next cycle.
- Reset asserted mid-operation: immediate return to the reset state, regardless of the clock.

Decomposition:
- Shared include/package idu_is_pkg:
  - Default widths PREG_W and IID_W.
  - Field widths for opcode (7), funct7 (7), funct3 (3), pc (64), imm (64).
  - Wake-port index constants for ALU is/rf forward, ALU result, mul1-3, div1-3 and LSU result (0..9).
- Sub-module idu_is_lsiq_slot, instantiated DEPTH times:
  - One entry's storage, the sticky-ready update with the WAKE_NUM comparator array, and clear-on-pop/flush.
- The top level holds the pointers, count, create_rdy, the head mux and the flush priority.

Test Plan:
- Reset then idle: create_rdy=1, count=0, issue_vld=0, issue_pc=0. Assert rst_clk low mid-traffic: same values immediately.
- Enqueue iid=3 with psrc1_vld=1, psrc1=12, not ready; psrc2_vld=0 -> issue_vld stays 0. Wake port 7 with preg 12 at cycle t -> issue_vld=1 at t+1 with issue_iid=3. Pop with issue_rdy=1 -> count=0.
- Same-cycle capture: create psrc1=20 (not ready) while wake_vld[0]=1 with wake_preg[0]=20 -> issue_vld=1 on the next cycle.
- In-order: enqueue A (not ready) then B (ready) -> B never issues while A waits. Wake A -> A issues, then B the following cycle.
- Fill DEPTH=8 -> create_rdy=0 and count=8. A further create is dropped. Same-cycle create + pop when full -> create refused, count=7. Then 8 cycles of create+pop with ready ops -> wrap-around in order, count constant.
- Flush while count=5, with create_vld=1 and a pop in the same cycle -> next cycle count=0, issue_vld=0, create_rdy=1, and no entry from the create survives.

Source files
------------

// File: rtl/idu_is_pkg.sv
// idu_is_pkg: shared widths and wake-port indices for the IDU issue queues
package idu_is_pkg;
  localparam int DEF_PREG_W = 6;
  localparam int DEF_IID_W = 5;
  localparam int OPC_W = 7;
  localparam int F7_W = 7;
  localparam int F3_W = 3;
  localparam int PC_W = 64;
  localparam int IMM_W = 64;
  localparam int WK_ALU_IS_FWD = 0;
  localparam int WK_ALU_RF_FWD = 1;
  localparam int WK_ALU_RES = 2;
  localparam int WK_MUL1 = 3;
  localparam int WK_MUL2 = 4;
  localparam int WK_MUL3 = 5;
  localparam int WK_DIV1 = 6;
  localparam int WK_DIV2 = 7;
  localparam int WK_DIV3 = 8;
  localparam int WK_LSU_RES = 9;
endpackage

// File: rtl/idu_is_lsiq_if.sv
// idu_is_lsiq_if: create, wakeup, issue and flush signals of the load/store issue queue
interface idu_is_lsiq_if import idu_is_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int WAKE_NUM = 10,
  parameter int PREG_W = DEF_PREG_W,
  parameter int IID_W = DEF_IID_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic rtu_global_flush;
  logic create_vld, create_rdy;
  logic [IID_W-1:0] create_iid;
  logic [OPC_W-1:0] create_opcode;
  logic [F7_W-1:0] create_funct7;
  logic [F3_W-1:0] create_funct3;
  logic [PC_W-1:0] create_pc;
  logic create_psrc1_vld, create_psrc1_ready, create_psrc2_vld, create_psrc2_ready;
  logic [PREG_W-1:0] create_psrc1, create_psrc2, create_pdst;
  logic create_pdst_vld, create_imm_vld;
  logic [IMM_W-1:0] create_imm;
  logic [WAKE_NUM-1:0] wake_vld;
  logic [WAKE_NUM*PREG_W-1:0] wake_preg;
  logic issue_vld, issue_rdy;
  logic [IID_W-1:0] issue_iid;
  logic [OPC_W-1:0] issue_opcode;
  logic [F7_W-1:0] issue_funct7;
  logic [F3_W-1:0] issue_funct3;
  logic [PC_W-1:0] issue_pc;
  logic issue_psrc1_vld, issue_psrc1_ready, issue_psrc2_vld, issue_psrc2_ready;
  logic [PREG_W-1:0] issue_psrc1, issue_psrc2, issue_pdst;
  logic issue_pdst_vld, issue_imm_vld;
  logic [IMM_W-1:0] issue_imm;
  logic [CNT_W-1:0] count;
  modport master (
    output rtu_global_flush, create_vld, create_iid, create_opcode, create_funct7, create_funct3,
           create_pc, create_psrc1_vld, create_psrc1_ready, create_psrc1, create_psrc2_vld,
           create_psrc2_ready, create_psrc2, create_pdst_vld, create_pdst, create_imm_vld,
           create_imm, wake_vld, wake_preg, issue_rdy,
    input  create_rdy, issue_vld, issue_iid, issue_opcode, issue_funct7, issue_funct3, issue_pc,
           issue_psrc1_vld, issue_psrc1_ready, issue_psrc1, issue_psrc2_vld, issue_psrc2_ready,
           issue_psrc2, issue_pdst_vld, issue_pdst, issue_imm_vld, issue_imm, count
  );
  modport slave (
    input  rtu_global_flush, create_vld, create_iid, create_opcode, create_funct7, create_funct3,
           create_pc, create_psrc1_vld, create_psrc1_ready, create_psrc1, create_psrc2_vld,
           create_psrc2_ready, create_psrc2, create_pdst_vld, create_pdst, create_imm_vld,
           create_imm, wake_vld, wake_preg, issue_rdy,
    output create_rdy, issue_vld, issue_iid, issue_opcode, issue_funct7, issue_funct3, issue_pc,
           issue_psrc1_vld, issue_psrc1_ready, issue_psrc1, issue_psrc2_vld, issue_psrc2_ready,
           issue_psrc2, issue_pdst_vld, issue_pdst, issue_imm_vld, issue_imm, count
  );
endinterface

// File: rtl/idu_is_lsiq_slot.sv
// idu_is_lsiq_slot: one queue entry with sticky source-ready tracking against all wake ports
module idu_is_lsiq_slot #(
  parameter int WAKE_NUM = 10,
  parameter int PREG_W = 6,
  parameter int PAY_W = 8
) (
  input  logic clk,
  input  logic rst_clk,
  input  logic wr,
  input  logic clr,
  input  logic [WAKE_NUM-1:0] wake_vld,
  input  logic [WAKE_NUM*PREG_W-1:0] wake_preg,
  input  logic [PAY_W-1:0] in_pay,
  input  logic in_s1_vld,
  input  logic in_s1_rdy,
  input  logic [PREG_W-1:0] in_s1,
  input  logic in_s2_vld,
  input  logic in_s2_rdy,
  input  logic [PREG_W-1:0] in_s2,
  output logic [PAY_W-1:0] pay,
  output logic s1_vld,
  output logic s1_rdy,
  output logic [PREG_W-1:0] s1,
  output logic s2_vld,
  output logic s2_rdy,
  output logic [PREG_W-1:0] s2,
  output logic ok
);
  logic vld, hit1, hit2;
  logic [PREG_W-1:0] c1, c2;
  // On a write the comparators look at the incoming sources so a same-cycle wake is captured
  always_comb begin
    c1 = wr ? in_s1 : s1;
    c2 = wr ? in_s2 : s2;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int k = 0; k < WAKE_NUM; k++) begin
      hit1 = hit1 | (wake_vld[k] & (wake_preg[k*PREG_W +: PREG_W] == c1));
      hit2 = hit2 | (wake_vld[k] & (wake_preg[k*PREG_W +: PREG_W] == c2));
    end
  end
  assign ok = (!s1_vld | s1_rdy) & (!s2_vld | s2_rdy);
  always_ff @(posedge clk or negedge rst_clk)
    if (!rst_clk) begin
      {vld, pay, s1_vld, s1_rdy, s1, s2_vld, s2_rdy, s2} <= '0;
    end else if (clr) begin
      {vld, pay, s1_vld, s1_rdy, s1, s2_vld, s2_rdy, s2} <= '0;
    end else if (wr) begin
      vld <= 1'b1;
      pay <= in_pay;
      s1_vld <= in_s1_vld;
      s1_rdy <= in_s1_rdy | hit1;
      s1 <= in_s1;
      s2_vld <= in_s2_vld;
      s2_rdy <= in_s2_rdy | hit2;
      s2 <= in_s2;
    end else if (vld) begin
      s1_rdy <= s1_rdy | hit1;
      s2_rdy <= s2_rdy | hit2;
    end
endmodule

// File: rtl/idu_is_lsiq.sv
// idu_is_lsiq: in-order multi-entry load/store issue queue with wakeup, backpressure and flush
module idu_is_lsiq import idu_is_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int WAKE_NUM = 10,
  parameter int PREG_W = DEF_PREG_W,
  parameter int IID_W = DEF_IID_W
) (
  input logic clk,
  input logic rst_clk,
  idu_is_lsiq_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int PAY_W = IID_W + OPC_W + F7_W + F3_W + PC_W + 1 + PREG_W + 1 + IMM_W;
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0] cnt;
  logic empty, do_push, do_pop;
  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] pay [DEPTH];
  logic [PREG_W-1:0] s1 [DEPTH];
  logic [PREG_W-1:0] s2 [DEPTH];
  logic [DEPTH-1:0] wr, clr, s1_vld, s1_rdy, s2_vld, s2_rdy, ok;
  assign empty = cnt == '0;
  assign q.create_rdy = cnt != (PTR_W+1)'(DEPTH);
  assign q.count = cnt;
  assign q.issue_vld = !empty & ok[head];
  assign do_push = q.create_vld & q.create_rdy & !q.rtu_global_flush;
  assign do_pop = q.issue_vld & q.issue_rdy & !q.rtu_global_flush;
  assign in_pay = {q.create_iid, q.create_opcode, q.create_funct7, q.create_funct3, q.create_pc,
                   q.create_pdst_vld, q.create_pdst & {PREG_W{q.create_pdst_vld}},
                   q.create_imm_vld, q.create_imm};
  // Popped slots are cleared, so the head slot of an empty queue already reads as all zeros
  assign {q.issue_iid, q.issue_opcode, q.issue_funct7, q.issue_funct3, q.issue_pc,
          q.issue_pdst_vld, q.issue_pdst, q.issue_imm_vld, q.issue_imm} = pay[head];
  assign q.issue_psrc1_vld = s1_vld[head];
  assign q.issue_psrc1_ready = s1_rdy[head];
  assign q.issue_psrc1 = s1[head];
  assign q.issue_psrc2_vld = s2_vld[head];
  assign q.issue_psrc2_ready = s2_rdy[head];
  assign q.issue_psrc2 = s2[head];
  always_comb begin
    wr = '0;
    clr = {DEPTH{q.rtu_global_flush}};
    wr[tail] = do_push;
    clr[head] = clr[head] | do_pop;
  end
  always_ff @(posedge clk or negedge rst_clk)
    if (!rst_clk) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else if (q.rtu_global_flush) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
    end else begin
      head <= head + PTR_W'(do_pop);
      tail <= tail + PTR_W'(do_push);
      cnt <= cnt + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    idu_is_lsiq_slot #(.WAKE_NUM(WAKE_NUM), .PREG_W(PREG_W), .PAY_W(PAY_W)) u_slot (
      .clk(clk),
      .rst_clk(rst_clk),
      .wr(wr[i]),
      .clr(clr[i]),
      .wake_vld(q.wake_vld),
      .wake_preg(q.wake_preg),
      .in_pay(in_pay),
      .in_s1_vld(q.create_psrc1_vld),
      .in_s1_rdy(q.create_psrc1_ready),
      .in_s1(q.create_psrc1),
      .in_s2_vld(q.create_psrc2_vld),
      .in_s2_rdy(q.create_psrc2_ready),
      .in_s2(q.create_psrc2),
      .pay(pay[i]),
      .s1_vld(s1_vld[i]),
      .s1_rdy(s1_rdy[i]),
      .s1(s1[i]),
      .s2_vld(s2_vld[i]),
      .s2_rdy(s2_rdy[i]),
      .s2(s2[i]),
      .ok(ok[i])
    );
  end
endmodule

// File: tb/tb_idu_is_lsiq.sv
// tb_idu_is_lsiq: directed self-checking bench for the load/store issue queue
module tb_idu_is_lsiq;
  logic clk = 1'b0;
  logic rst_clk = 1'b0;
  int checks = 0;
  int failures = 0;
  int exp_q[$];
  idu_is_lsiq_if bus ();
  idu_is_lsiq dut (.clk(clk), .rst_clk(rst_clk), .q(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.rtu_global_flush = 0;
    bus.create_vld = 0;
    bus.create_iid = '0;
    bus.create_opcode = '0;
    bus.create_funct7 = '0;
    bus.create_funct3 = '0;
    bus.create_pc = '0;
    bus.create_psrc1_vld = 0;
    bus.create_psrc1_ready = 0;
    bus.create_psrc1 = '0;
    bus.create_psrc2_vld = 0;
    bus.create_psrc2_ready = 0;
    bus.create_psrc2 = '0;
    bus.create_pdst_vld = 0;
    bus.create_pdst = '0;
    bus.create_imm_vld = 0;
    bus.create_imm = '0;
    bus.wake_vld = '0;
    bus.wake_preg = '0;
    bus.issue_rdy = 0;
  endtask
  task automatic set_op(input int iid, input bit s1v, input bit s1r, input int s1, input int pc);
    bus.create_vld = 1;
    bus.create_iid = 5'(iid);
    bus.create_opcode = 7'h03;
    bus.create_psrc1_vld = s1v;
    bus.create_psrc1_ready = s1r;
    bus.create_psrc1 = 6'(s1);
    bus.create_psrc2_vld = 0;
    bus.create_pdst_vld = 0;
    bus.create_pdst = 6'd33;
    bus.create_pc = 64'(pc);
  endtask
  task automatic wake(input int port, input int preg);
    bus.wake_vld[port] = 1'b1;
    bus.wake_preg[port*6 +: 6] = 6'(preg);
  endtask
  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_create_rdy", bus.create_rdy, 1);
    chk("rst_count", bus.count, 0);
    chk("rst_issue_vld", bus.issue_vld, 0);
    chk("rst_issue_pc", bus.issue_pc, 0);
    rst_clk = 1;
    tick();
    set_op(1, 0, 0, 0, 'h10);
    tick();
    set_op(2, 0, 0, 0, 'h20);
    tick();
    bus.create_vld = 0;
    chk("pre_rst_count", bus.count, 2);
    chk("pre_rst_issue_vld", bus.issue_vld, 1);
    rst_clk = 0;
    #1;
    chk("async_rst_count", bus.count, 0);
    chk("async_rst_create_rdy", bus.create_rdy, 1);
    chk("async_rst_issue_vld", bus.issue_vld, 0);
    chk("async_rst_issue_pc", bus.issue_pc, 0);
    #2 rst_clk = 1;
    tick();
    set_op(3, 1, 0, 12, 'h100);
    tick();
    bus.create_vld = 0;
    chk("wait_count", bus.count, 1);
    chk("wait_issue_vld", bus.issue_vld, 0);
    chk("pdst_masked", bus.issue_pdst, 0);
    tick();
    chk("wait2_issue_vld", bus.issue_vld, 0);
    wake(7, 12);
    #1;
    chk("wake_not_comb", bus.issue_vld, 0);
    tick();
    bus.wake_vld = '0;
    chk("woken_issue_vld", bus.issue_vld, 1);
    chk("woken_issue_iid", bus.issue_iid, 3);
    chk("woken_issue_pc", bus.issue_pc, 'h100);
    bus.issue_rdy = 1;
    tick();
    bus.issue_rdy = 0;
    chk("pop_count", bus.count, 0);
    chk("pop_issue_vld", bus.issue_vld, 0);
    set_op(5, 1, 0, 20, 'h200);
    bus.create_pdst_vld = 1;
    bus.create_pdst = 6'd45;
    wake(0, 20);
    tick();
    idle();
    chk("cap_issue_vld", bus.issue_vld, 1);
    chk("cap_issue_iid", bus.issue_iid, 5);
    chk("cap_issue_pdst", bus.issue_pdst, 45);
    bus.issue_rdy = 1;
    tick();
    bus.issue_rdy = 0;
    chk("cap_pop_count", bus.count, 0);
    set_op(1, 1, 0, 30, 'h300);
    tick();
    set_op(2, 0, 0, 0, 'h304);
    tick();
    bus.create_vld = 0;
    bus.issue_rdy = 1;
    chk("ord_count", bus.count, 2);
    chk("ord_blocked_vld", bus.issue_vld, 0);
    chk("ord_head_iid", bus.issue_iid, 1);
    tick();
    tick();
    chk("ord_still_count", bus.count, 2);
    wake(9, 30);
    tick();
    bus.wake_vld = '0;
    chk("ord_a_vld", bus.issue_vld, 1);
    chk("ord_a_iid", bus.issue_iid, 1);
    tick();
    chk("ord_b_vld", bus.issue_vld, 1);
    chk("ord_b_iid", bus.issue_iid, 2);
    chk("ord_b_count", bus.count, 1);
    tick();
    chk("ord_done_count", bus.count, 0);
    bus.issue_rdy = 0;
    for (int i = 0; i < 8; i++) begin
      set_op(10 + i, 0, 0, 0, i);
      tick();
    end
    set_op(31, 0, 0, 0, 'h31);
    chk("full_count", bus.count, 8);
    chk("full_create_rdy", bus.create_rdy, 0);
    tick();
    chk("drop_count", bus.count, 8);
    chk("drop_head_iid", bus.issue_iid, 10);
    bus.issue_rdy = 1;
    tick();
    chk("full_pop_count", bus.count, 7);
    chk("full_pop_iid", bus.issue_iid, 11);
    for (int i = 11; i < 18; i++) exp_q.push_back(i);
    for (int i = 0; i < 8; i++) begin
      set_op(20 + i, 0, 0, 0, 'h40 + i);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(20 + i);
      chk("wrap_count", bus.count, 7);
      chk("wrap_iid", bus.issue_iid, exp_q[0]);
    end
    bus.create_vld = 0;
    tick();
    tick();
    chk("pre_flush_count", bus.count, 5);
    chk("pre_flush_iid", bus.issue_iid, 23);
    bus.rtu_global_flush = 1;
    set_op(9, 0, 0, 0, 'h900);
    tick();
    idle();
    chk("flush_count", bus.count, 0);
    chk("flush_issue_vld", bus.issue_vld, 0);
    chk("flush_create_rdy", bus.create_rdy, 1);
    chk("flush_issue_iid", bus.issue_iid, 0);
    tick();
    chk("flush_no_create", bus.count, 0);
    set_op(6, 0, 0, 0, 'h600);
    tick();
    bus.create_vld = 0;
    chk("post_flush_vld", bus.issue_vld, 1);
    chk("post_flush_iid", bus.issue_iid, 6);
    chk("post_flush_count", bus.count, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
